// File: rtl/dct_coeff_accum.sv
// One 2-D DCT coefficient lane: streams 64 row-major pixels, multiplies each by the
// external cosine LUT term and accumulates. Optional output saturation via DCT_SAT_EN.
module dct_coeff_accum #(
    parameter int PIX_W = 9,
    parameter int ACC_W = 48,
    parameter int SHIFT = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PIX_W-1:0] in_pix,
    output logic [2:0]              n1,
    output logic [2:0]              n2,
    input  logic signed [31:0]      cos_term,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_coef,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high and flush is low; valid never depends on ready, and out_coef/out_valid stay
    // stable while out_valid && !out_ready.

    localparam int PROD_W = PIX_W + 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [5:0]               pix_cnt;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_v;
    logic                     prod_first;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  coef_nxt;
    logic                     accept;

    assign n1        = pix_cnt[5:3];
    assign n2        = pix_cnt[2:0];
    assign dbg_state = state;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        if (state == ACCUM) begin
            in_ready = 1'b1;
        end
        if (flush) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && pix_cnt == 6'd63) state_nxt = DRAIN;
                DRAIN:   state_nxt = HOLD;
                HOLD:    if (out_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // The first product of a block reloads acc, so no separate clear is needed.
    always_comb begin
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_nxt  = acc;
        if (prod_v) begin
            acc_nxt = prod_first ? prod_ext : acc + prod_ext;
        end
    end

`ifdef DCT_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    localparam logic signed [ACC_W-1:0] COEF_MAX = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] COEF_MIN = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        shifted = acc_nxt >>> SHIFT;
        if (shifted > COEF_MAX) begin
            coef_nxt = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (shifted < COEF_MIN) begin
            coef_nxt = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            coef_nxt = OUT_W'(shifted);
        end
    end
`else
    always_comb begin
        coef_nxt = OUT_W'(acc_nxt >>> SHIFT);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            prod       <= '0;
            prod_v     <= 1'b0;
            prod_first <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_coef   <= '0;
        end else begin
            acc <= acc_nxt;
            if (flush) begin
                pix_cnt   <= '0;
                prod_v    <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                prod_v <= accept;
                if (accept) begin
                    prod       <= in_pix * cos_term;
                    prod_first <= (pix_cnt == 6'd0);
                    pix_cnt    <= pix_cnt + 6'd1;
                end
                // DRAIN absorbs the last product, so the coefficient comes from acc_nxt.
                if (state == DRAIN) begin
                    out_coef  <= coef_nxt;
                    out_valid <= 1'b1;
                end else if (state == HOLD && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_coeff_accum.sv
// Bench for dct_coeff_accum: two lanes (16-bit and 8-bit outputs) share one pixel stream
// and are checked against a plain-arithmetic sum-of-products model.
module tb_dct_coeff_accum;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic signed [8:0] in_pix;
    logic              out_ready;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [2:0]  n1_a, n2_a, n1_b, n2_b;
    logic [31:0] cos_a, cos_b;
    logic [15:0] out_coef_a;
    logic [7:0]  out_coef_b;
    logic [1:0]  dbg_a, dbg_b;

    logic signed [31:0] lut[64];
    logic signed [8:0]  blk[64];
    logic [23:0]        exp_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;

    assign cos_a = lut[{n1_a, n2_a}];
    assign cos_b = lut[{n1_b, n2_b}];

    always #5 clk = ~clk;

    dct_coeff_accum #(.PIX_W(9), .ACC_W(48), .SHIFT(8), .OUT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pix(in_pix), .n1(n1_a), .n2(n2_a), .cos_term(cos_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_coef(out_coef_a), .dbg_state(dbg_a)
    );

    dct_coeff_accum #(.PIX_W(9), .ACC_W(48), .SHIFT(8), .OUT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pix(in_pix), .n1(n1_b), .n2(n2_b), .cos_term(cos_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_coef(out_coef_b), .dbg_state(dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: coefficient = floor(sum(pix*lut) / 2^8), then wrap or clamp to w bits.
    function automatic longint fit(input longint acc, input int w);
        longint sh;
        longint hi;
        longint lo;
        sh = acc >>> 8;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
`ifdef DCT_SAT_EN
        if (sh > hi) sh = hi;
        if (sh < lo) sh = lo;
`else
        if (hi < lo) sh = lo;
`endif
        return sh;
    endfunction

    function automatic logic [23:0] model();
        longint acc;
        longint c16;
        longint c8;
        acc = 0;
        for (int i = 0; i < 64; i++) acc += longint'(blk[i]) * longint'(lut[i]);
        c16 = fit(acc, 16);
        c8  = fit(acc, 8);
        return {c16[15:0], c8[7:0]};
    endfunction

    task automatic load_dct_lut();
        real pi;
        pi = 3.14159265358979;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                lut[r*8+c] = $rtoi(256.0 * $cos((2*r+1)*6*pi/16.0) * $cos((2*c+1)*3*pi/16.0));
    endtask

    task automatic load_rand_lut();
        for (int i = 0; i < 64; i++) lut[i] = $urandom();
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 64; i++) blk[i] = 9'($urandom_range(0, 511));
    endtask

    task automatic feed(input int count, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_pix   = 9'($urandom_range(0, 511));
                step();
            end
            check("pix_index", {26'd0, n1_a, n2_a}, 32'(i));
            in_valid = 1'b1;
            in_pix   = blk[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted pixel 63.
    task automatic finish_block(input int hold_cycles);
        logic [23:0] e;
        logic [15:0] held;
        check("drain_valid", {31'd0, out_valid_a}, 32'd0);
        check("drain_ready", {31'd0, in_ready_a}, 32'd0);
        step();
        check("out_valid_a", {31'd0, out_valid_a}, 32'd1);
        check("out_valid_b", {31'd0, out_valid_b}, 32'd1);
        e = exp_q.pop_front();
        check("coef16", {16'd0, out_coef_a}, {16'd0, e[23:8]});
        check("coef8", {24'd0, out_coef_b}, {24'd0, e[7:0]});
        held     = out_coef_a;
        in_valid = 1'b1;
        in_pix   = 9'($urandom_range(0, 511));
        for (int k = 0; k < hold_cycles; k++) begin
            step();
            check("hold_coef", {16'd0, out_coef_a}, {16'd0, held});
            check("hold_valid", {31'd0, out_valid_a}, 32'd1);
            check("hold_ready", {31'd0, in_ready_a}, 32'd0);
            check("hold_index", {26'd0, n1_a, n2_a}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid_a}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready_a}, 32'd1);
        check("post_hs_index", {26'd0, n1_a, n2_a}, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int gap_pct, input int hold_cycles);
        exp_q.push_back(model());
        feed(64, gap_pct);
        finish_block(hold_cycles);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pix    = '0;
        out_ready = 1'b0;
        load_dct_lut();
        clear_blk();
        step();
        step();
        check("rst_ready", {31'd0, in_ready_a}, 32'd1);
        check("rst_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_coef", {16'd0, out_coef_a}, 32'd0);
        check("rst_index", {26'd0, n1_a, n2_a}, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed cases with the k1=6,k2=3 cosine table.
        for (int i = 0; i < 64; i++) blk[i] = 9'sd1;
        send_block(0, 0);
        check("ones_coef", {16'd0, out_coef_a}, 32'd0);
        clear_blk();
        blk[0] = 9'sd100;
        send_block(0, 1);
        clear_blk();
        blk[10] = -9'sd128;
        send_block(10, 2);
        clear_blk();
        blk[10] = 9'sd255;
        send_block(0, 5);

        // Reset in the middle of a block, then a clean block.
        rand_blk();
        feed(30, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_index", {26'd0, n1_a, n2_a}, 32'd0);
        check("midrst_ready", {31'd0, in_ready_a}, 32'd1);
        step();
        rst_n = 1'b1;
        clear_blk();
        blk[0] = 9'sd100;
        send_block(0, 1);
        check("after_rst_coef", {16'd0, out_coef_a}, 32'd31);

        // Flush in the middle of a block; the pixel presented with flush is dropped.
        rand_blk();
        feed(30, 20);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pix   = 9'sd55;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_index", {26'd0, n1_a, n2_a}, 32'd0);
        check("flush_ready", {31'd0, in_ready_a}, 32'd1);
        clear_blk();
        blk[0] = 9'sd100;
        send_block(0, 1);
        check("after_flush_coef", {16'd0, out_coef_a}, 32'd31);

        // Flush while a coefficient is held discards it.
        rand_blk();
        feed(64, 0);
        step();
        check("pre_flush_valid", {31'd0, out_valid_a}, 32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("hold_flush_valid", {31'd0, out_valid_a}, 32'd0);
        check("hold_flush_ready", {31'd0, in_ready_a}, 32'd1);

        // Random tables and pixels, random gaps and hold lengths.
        for (int b = 0; b < 8; b++) begin
            load_rand_lut();
            rand_blk();
            send_block(int'($urandom_range(0, 40)), int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
